// File: rtl/spi_adis_slave.sv
// ADIS16209-style SPI mode-3 responder with a 128-byte register image; reads answer one frame late.
// Pin edges act 3 clk after they occur (2-FF sync + edge register); commits land 1 clk later; no backpressure.
module spi_adis_slave #(
  parameter logic [15:0] PROD_ID = 16'h3F51
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic        ld_en,
  input  logic [6:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [2:0]  sclk_q;
  logic [2:0]  cs_q;
  logic [1:0]  mosi_q;
  logic        armed;
  logic [4:0]  bit_cnt;
  logic [15:0] rx_sr;
  logic [15:0] tx_sr;
  logic [15:0] resp;
  logic        commit;
  logic        err_pend;
  logic [7:0]  mem [128];

  logic        sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic        wr_prod, ld_prod;
  logic [15:0] rd_word;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign mosi_s    = mosi_q[1];
  assign wr_prod   = (rx_sr[14:9] == 6'h25);
  assign ld_prod   = (ld_addr[6:1] == 6'h25);
  assign rd_word   = wr_prod ? PROD_ID : {mem[{rx_sr[14:9], 1'b1}], mem[{rx_sr[14:9], 1'b0}]};

  // cs history resets low so a chip select already held low at reset exit never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b111;
      cs_q   <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      bit_cnt   <= 5'd0;
      rx_sr     <= 16'h0000;
      tx_sr     <= 16'h0000;
      resp      <= 16'h0000;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      commit    <= 1'b0;
      err_pend  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      commit    <= 1'b0;
      err_pend  <= 1'b0;
      frame_err <= err_pend;
      if (cs_q[1]) armed <= 1'b1;
      if (commit) resp <= rx_sr[15] ? 16'h0000 : rd_word;

      if (cs_rise) begin
        if (state != IDLE && bit_cnt != 5'd0 && bit_cnt != 5'd16) err_pend <= 1'b1;
        state   <= IDLE;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall && armed) begin
              state   <= SHIFT;
              bit_cnt <= 5'd0;
              tx_sr   <= resp;
              miso    <= resp[15];
              miso_oe <= 1'b1;
            end
          end
          SHIFT: begin
            if (sclk_rise) begin
              rx_sr   <= {rx_sr[14:0], mosi_s};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                state  <= DONE;
                commit <= 1'b1;
              end
            end else if (sclk_fall && bit_cnt != 5'd0) begin
              tx_sr <= {tx_sr[14:0], 1'b0};
              miso  <= tx_sr[14];
            end
          end
          DONE: begin
            // Keep counting overrun edges (saturating) so a long frame is still flagged at cs rise.
            if (sclk_rise) begin
              if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end else if (sclk_fall) begin
              tx_sr <= {tx_sr[14:0], 1'b0};
              miso  <= tx_sr[14];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // SPI write is applied after the fabric load so it wins on a shared byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'h00;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (ld_en && !ld_prod) begin
        mem[{ld_addr[6:1], 1'b0}] <= ld_data[7:0];
        mem[{ld_addr[6:1], 1'b1}] <= ld_data[15:8];
      end
      if (commit && rx_sr[15] && !wr_prod) begin
        mem[rx_sr[14:8]] <= rx_sr[7:0];
        wr_strobe        <= 1'b1;
        wr_addr          <= rx_sr[14:8];
        wr_data          <= rx_sr[7:0];
      end
    end
  end

endmodule

// File: tb/tb_spi_adis_slave.sv
// Randomised bench for spi_adis_slave: a bus-level master drives frames while monitors score miso words,
// write strobes and framing errors against a byte-array model of the register image.
module tb_spi_adis_slave;

  localparam logic [15:0] PROD = 16'h3F51;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        ld_en = 1'b0;
  logic [6:0]  ld_addr = 7'h00;
  logic [15:0] ld_data = 16'h0000;
  logic        miso, miso_oe, wr_strobe, frame_err;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;

  spi_adis_slave #(.PROD_ID(PROD)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte image, pending response word, expectation queues.
  typedef struct {
    logic [15:0] word;
    int          nbits;
    bit          chk;
    int          oe;      // 0/1 expected miso_oe during the frame, 2 = don't check
  } frm_t;

  logic [7:0]  mem_m [128];
  logic [15:0] resp_m;
  bit          resp_known;
  frm_t        frm_q[$];
  logic [14:0] wr_q[$];
  int          err_pend_m = 0;

  function automatic bit is_prod(input logic [6:0] a);
    return a[6:1] == 6'h25;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    resp_m = 16'h0000;
    resp_known = 1'b1;
  endtask

  task automatic model_ld(input logic [6:0] a, input logic [15:0] d);
    if (!is_prod(a)) begin
      mem_m[{a[6:1], 1'b0}] = d[7:0];
      mem_m[{a[6:1], 1'b1}] = d[15:8];
    end
  endtask

  task automatic fabric_load(input logic [6:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    model_ld(a, d);
    repeat (2) @(negedge clk);
  endtask

  // One SPI frame. armed=0 means the DUT must ignore it; rst_at >= 0 pulses reset after that bit.
  task automatic spi_frame(input logic [15:0] w, input int nbits, input bit armed,
                           input bit do_ld, input logic [6:0] la, input logic [15:0] ldd,
                           input int rst_at);
    frm_t e;
    logic [15:0] sh;
    e.word = resp_m;
    e.nbits = nbits;
    e.chk = armed && resp_known && (rst_at < 0);
    e.oe = (rst_at >= 0) ? 2 : (armed ? 1 : 0);
    frm_q.push_back(e);
    if (armed && rst_at < 0) begin
      if (do_ld) model_ld(la, ldd);
      if (nbits == 16) begin
        if (w[15]) begin
          if (!is_prod(w[14:8])) begin
            mem_m[w[14:8]] = w[7:0];
            wr_q.push_back({w[14:8], w[7:0]});
          end
          resp_m = 16'h0000;
        end else begin
          resp_m = is_prod(w[14:8]) ? PROD
                 : {mem_m[{w[14:9], 1'b1}], mem_m[{w[14:9], 1'b0}]};
        end
        resp_known = 1'b1;
      end else if (nbits > 16) begin
        err_pend_m++;
        resp_known = 1'b0;
      end else if (nbits > 0) begin
        err_pend_m++;
      end
    end
    sh = w;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = sh[15];
      sh = {sh[14:0], 1'b0};
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (i == 15 && do_ld) begin
        repeat (3) @(negedge clk);
        ld_en = 1'b1; ld_addr = la; ld_data = ldd;
        @(negedge clk);
        ld_en = 1'b0;
      end else begin
        repeat (4) @(negedge clk);
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
      end
    end
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("wr_drain", wr_q.size(), 0);
    chk("err_drain", err_pend_m, 0);
    chk("frame_drain", frm_q.size(), 0);
    chk("oe_idle", {31'h0, miso_oe}, 0);
  endtask

  task automatic frame(input logic [15:0] w);
    spi_frame(w, 16, 1'b1, 1'b0, 7'h00, 16'h0000, -1);
  endtask

  // miso monitor: assembles bits at the master's sampling edge, compares at cs_n rise.
  initial begin : mon_miso
    frm_t e;
    logic [31:0] cap, tmp, exp;
    int n;
    forever begin
      @(negedge cs_n);
      chk("frame_expected", {31'h0, frm_q.size() != 0}, 1);
      if (frm_q.size() != 0) e = frm_q.pop_front();
      else begin e.word = 0; e.nbits = 0; e.chk = 0; e.oe = 2; end
      cap = 0;
      n = 0;
      forever begin
        @(posedge sclk or posedge cs_n);
        if (cs_n) break;
        if (n == 0 && e.oe != 2) chk("miso_oe_active", {31'h0, miso_oe}, e.oe);
        cap = {cap[30:0], miso};
        n++;
      end
      if (e.chk && n > 0) begin
        tmp = {e.word, 16'h0000};
        exp = tmp >> (32 - n);
        chk("miso_word", cap, exp);
      end
    end
  end

  initial begin : mon_wr
    logic [14:0] x;
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        chk("wr_expected", {31'h0, wr_q.size() != 0}, 1);
        if (wr_q.size() != 0) begin
          x = wr_q.pop_front();
          chk("wr_addr_data", {17'h0, wr_addr, wr_data}, {17'h0, x});
        end
      end
    end
  end

  initial begin : mon_err
    forever begin
      @(negedge clk);
      if (frame_err) begin
        chk("err_expected", {31'h0, err_pend_m != 0}, 1);
        if (err_pend_m > 0) err_pend_m--;
      end
    end
  end

  initial begin : watchdog
    #600000;
    failures++;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    logic [6:0]  a;
    logic [15:0] d;
    int          op;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_miso", {31'h0, miso}, 0);
    chk("rst_miso_oe", {31'h0, miso_oe}, 0);
    chk("rst_wr_strobe", {31'h0, wr_strobe}, 0);
    chk("rst_wr_addr", {25'h0, wr_addr}, 0);
    chk("rst_wr_data", {24'h0, wr_data}, 0);
    chk("rst_frame_err", {31'h0, frame_err}, 0);

    frame(16'h4A00); frame(16'h0000);
    frame(16'h9C12); frame(16'h1C00); frame(16'h0000);
    fabric_load(7'h04, 16'hABCD); frame(16'h0400); frame(16'h0000);
    fabric_load(7'h05, 16'hABCD); frame(16'h0400); frame(16'h0000);
    frame(16'h0400);
    spi_frame(16'h1234, 9, 1'b1, 1'b0, 7'h00, 16'h0000, -1);
    frame(16'h0000);
    frame(16'hCA55); frame(16'h4A00); frame(16'h0000);
    spi_frame(16'h8477, 16, 1'b1, 1'b1, 7'h04, 16'h1122, -1);
    frame(16'h0400); frame(16'h0000);
    spi_frame(16'h0400, 17, 1'b1, 1'b0, 7'h00, 16'h0000, -1);
    frame(16'h0000);
    spi_frame(16'h8133, 16, 1'b0, 1'b0, 7'h00, 16'h0000, 5);
    frame(16'h0000);
    frame(16'h8155); frame(16'h0100); frame(16'h0000);

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 3);
      a = 7'($urandom);
      d = 16'($urandom);
      if (k % 10 == 0) a = 7'h4A;
      case (op)
        0: fabric_load(a, d);
        1: frame({1'b1, a, d[7:0]});
        2: frame({1'b0, a, d[7:0]});
        default: spi_frame({1'b0, a, d[7:0]}, $urandom_range(1, 15), 1'b1, 1'b0, 7'h00, 16'h0000, -1);
      endcase
    end
    frame(16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
